dmem_resp: RTL and testbench

Memory-side responder for the data-memory port: accepts load/store requests from the MEM stage, applies per-byte write enables produced by the store byte-enable logic, performs a registered word read, and returns aligned, sign- or zero-extended load data through a valid/ready response handshake. It sits between the MEM-stage request signals and the writeback-stage load result, replacing a combinational read path with one outstanding, back-pressurable transaction.

---
 rtl/dmem_resp.sv | 157 +++++++++++++++
 tb/tb_dmem_resp.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// Data-memory responder: one outstanding load/store with a registered word read and a
// valid/ready response. Optional misalignment trapping via DMEM_MISALIGN_TRAP_EN.
module dmem_resp #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        funct3,
    input  logic [31:0]       wdata,
    input  logic [3:0]        byteEnable,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rdata,
    output logic              misaligned
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

    typedef enum logic [0:0] {StIdle, StResp} state_e;

    state_e state_q, state_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     word_q, word_d;
    logic [1:0]      off_q, off_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            is_load_q, is_load_d;
    logic            mis_q, mis_d;

    logic            accept;
    logic [IdxW-1:0] idx;
    logic            mis_req;
    logic [31:0]     wr_data;
    logic [3:0]      wr_be;
    logic [7:0]      sel_byte;
    logic [15:0]     sel_half;
    logic            unused_addr;

    assign unused_addr = ^addr[ADDR_W-1:IdxW+2];

    always_comb begin
        idx       = addr[IdxW+1:2];
        req_ready = (state_q == StIdle) || rsp_ready;
        accept    = req_valid && req_ready;

`ifdef DMEM_MISALIGN_TRAP_EN
        mis_req = (((funct3 == 3'b001) || (funct3 == 3'b101)) && addr[0]) ||
                  ((funct3 == 3'b010) && (addr[1:0] != 2'b00));
`else
        mis_req = 1'b0;
`endif

        unique case (funct3[1:0])
            2'b00:   wr_data = {4{wdata[7:0]}};
            2'b01:   wr_data = {2{wdata[15:0]}};
            default: wr_data = wdata;
        endcase

        // A store on the same edge as reset must not land in the array.
        wr_be = (accept && we && !reset && !mis_req) ? byteEnable : 4'b0000;
    end

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        word_d      = word_q;
        off_d       = off_q;
        funct3_d    = funct3_q;
        is_load_d   = is_load_q;
        mis_d       = mis_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready && !accept) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            rsp_valid_d = 1'b1;
            word_d      = we ? 32'h0 : mem_q[idx];
            off_d       = addr[1:0];
            funct3_d    = funct3;
            is_load_d   = !we;
            mis_d       = mis_req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            word_q      <= 32'h0;
            off_q       <= 2'b00;
            funct3_q    <= 3'b000;
            is_load_q   <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            word_q      <= word_d;
            off_q       <= off_d;
            funct3_q    <= funct3_d;
            is_load_q   <= is_load_d;
            mis_q       <= mis_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
                mem_q[idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        unique case (off_q)
            2'b00:   sel_byte = word_q[7:0];
            2'b01:   sel_byte = word_q[15:8];
            2'b10:   sel_byte = word_q[23:16];
            default: sel_byte = word_q[31:24];
        endcase
        sel_half = off_q[1] ? word_q[31:16] : word_q[15:0];

        rdata = 32'h0;
        if (rsp_valid_q && is_load_q && !mis_q) begin
            case (funct3_q)
                3'b000:  rdata = {{24{sel_byte[7]}}, sel_byte};
                3'b100:  rdata = {24'h0, sel_byte};
                3'b001:  rdata = {{16{sel_half[15]}}, sel_half};
                3'b101:  rdata = {16'h0, sel_half};
                3'b010:  rdata = word_q;
                default: rdata = 32'h0;
            endcase
        end

        rsp_valid  = rsp_valid_q;
        misaligned = rsp_valid_q && mis_q;
    end

endmodule

// File: tb/tb_dmem_resp.sv
// Table-driven bench for dmem_resp plus hand-written backpressure and reset sequences.
// Expectations follow DMEM_MISALIGN_TRAP_EN when the macro is defined.
module tb_dmem_resp;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        we;
    logic [31:0] addr;
    logic [2:0]  funct3;
    logic [31:0] wdata;
    logic [3:0]  byteEnable;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rdata;
    logic        misaligned;

    int checks   = 0;
    int failures = 0;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit Trap = 1'b1;
`else
    localparam bit Trap = 1'b0;
`endif

    always #5 clk = ~clk;

    dmem_resp #(
        .DEPTH_WORDS(1024),
        .ADDR_W     (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .we         (we),
        .addr       (addr),
        .funct3     (funct3),
        .wdata      (wdata),
        .byteEnable (byteEnable),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rdata      (rdata),
        .misaligned (misaligned)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic w, input logic [31:0] a,
                       input logic [2:0] f, input logic [31:0] d, input logic [3:0] b,
                       input logic [31:0] er, input logic em);
        vec_t v;
        v.name = name; v.we = w; v.addr = a; v.f3 = f; v.wdata = d; v.be = b;
        v.exp_rdata = er; v.exp_mis = em;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [2:0] f,
                         input logic [31:0] d, input logic [3:0] b);
        req_valid = 1'b1; we = w; addr = a; funct3 = f; wdata = d; byteEnable = b;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; we = 1'b0; addr = '0; funct3 = '0;
        wdata = '0; byteEnable = '0; rsp_ready = 1'b1;

        add("sw_10",        1, 32'h10, 3'b010, 32'hDEADBEEF, 4'b1111, 32'h0, 0);
        add("lw_10",        0, 32'h10, 3'b010, 32'h0,        4'b0000, 32'hDEADBEEF, 0);
        add("sw_20_clr",    1, 32'h20, 3'b010, 32'h0,        4'b1111, 32'h0, 0);
        add("sb_22",        1, 32'h22, 3'b000, 32'h00000080, 4'b0100, 32'h0, 0);
        add("lb_22",        0, 32'h22, 3'b000, 32'h0,        4'b0000, 32'hFFFFFF80, 0);
        add("lbu_22",       0, 32'h22, 3'b100, 32'h0,        4'b0000, 32'h00000080, 0);
        add("lw_20",        0, 32'h20, 3'b010, 32'h0,        4'b0000, 32'h00800000, 0);
        add("sw_30_clr",    1, 32'h30, 3'b010, 32'h0,        4'b1111, 32'h0, 0);
        add("sh_32",        1, 32'h32, 3'b001, 32'h00008001, 4'b1100, 32'h0, 0);
        add("lh_32",        0, 32'h32, 3'b001, 32'h0,        4'b0000, 32'hFFFF8001, 0);
        add("lhu_32",       0, 32'h32, 3'b101, 32'h0,        4'b0000, 32'h00008001, 0);
        add("lh_30",        0, 32'h30, 3'b001, 32'h0,        4'b0000, 32'h00000000, 0);
        add("lb_33",        0, 32'h33, 3'b000, 32'h0,        4'b0000, 32'hFFFFFF80, 0);
        add("lb_32",        0, 32'h32, 3'b000, 32'h0,        4'b0000, 32'h00000001, 0);
        add("ld_f3_011",    0, 32'h10, 3'b011, 32'h0,        4'b0000, 32'h0, 0);
        add("ld_f3_110",    0, 32'h10, 3'b110, 32'h0,        4'b0000, 32'h0, 0);
        add("lw_be_ignore", 0, 32'h10, 3'b010, 32'hFFFFFFFF, 4'b1111, 32'hDEADBEEF, 0);
        add("lw_10_again",  0, 32'h10, 3'b010, 32'h0,        4'b0000, 32'hDEADBEEF, 0);
        add("sw_50_clr",    1, 32'h50, 3'b010, 32'h0,        4'b1111, 32'h0, 0);
        add("sh_50_lo",     1, 32'h50, 3'b001, 32'h00001234, 4'b0011, 32'h0, 0);
        add("lw_50",        0, 32'h50, 3'b010, 32'h0,        4'b0000, 32'h00001234, 0);
        add("sw_60",        1, 32'h60, 3'b010, 32'hCAFEF00D, 4'b1111, 32'h0, 0);
        add("lw_60",        0, 32'h60, 3'b010, 32'h0,        4'b0000, 32'hCAFEF00D, 0);
        add("sw_40",        1, 32'h40, 3'b010, 32'h12345678, 4'b1111, 32'h0, 0);
        add("sw_41_mis",    1, 32'h41, 3'b010, 32'hAABBCCDD, 4'b1111, 32'h0, Trap);
        add("lw_40",        0, 32'h40, 3'b010, 32'h0, 4'b0000,
            Trap ? 32'h12345678 : 32'hAABBCCDD, 0);
        add("lw_41_mis",    0, 32'h41, 3'b010, 32'h0, 4'b0000,
            Trap ? 32'h0 : 32'hAABBCCDD, Trap);
        add("lh_41_mis",    0, 32'h41, 3'b001, 32'h0, 4'b0000,
            Trap ? 32'h0 : 32'hFFFFCCDD, Trap);
        add("lb_41",        0, 32'h41, 3'b000, 32'h0, 4'b0000,
            Trap ? 32'h00000056 : 32'hFFFFFFCC, 0);
        add("lhu_42",       0, 32'h42, 3'b101, 32'h0, 4'b0000,
            Trap ? 32'h00001234 : 32'h0000AABB, 0);

        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_misaligned", 32'(misaligned), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h1);

        // Consecutive vectors are accepted on consecutive edges: back-to-back throughput.
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].addr, vecs[i].f3, vecs[i].wdata, vecs[i].be);
            check({vecs[i].name, "_req_ready"}, 32'(req_ready), 32'h1);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            check({vecs[i].name, "_rsp_valid"}, 32'(rsp_valid), 32'h1);
            check({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
            check({vecs[i].name, "_mis"}, 32'(misaligned), 32'(vecs[i].exp_mis));
        end
        @(posedge clk);
        #1;
        check("drain_rsp_valid", 32'(rsp_valid), 32'h0);

        // Backpressure: response held, new request blocked, then accepted on release.
        @(negedge clk);
        drive(0, 32'h10, 3'b010, 32'h0, 4'b0000);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        drive(0, 32'h20, 3'b010, 32'h0, 4'b0000);
        check("bp_first_rdata", rdata, 32'hDEADBEEF);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("bp_hold_rsp_valid", 32'(rsp_valid), 32'h1);
            check("bp_hold_rdata", rdata, 32'hDEADBEEF);
            check("bp_hold_req_ready", 32'(req_ready), 32'h0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        check("bp_release_req_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("bp_next_rsp_valid", 32'(rsp_valid), 32'h1);
        check("bp_next_rdata", rdata, 32'h00800000);

        // Reset with a pending response and a store presented on the reset edge.
        @(negedge clk);
        drive(0, 32'h10, 3'b010, 32'h0, 4'b0000);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check("rr_pending", 32'(rsp_valid), 32'h1);
        @(negedge clk);
        reset     = 1'b1;
        rsp_ready = 1'b1;
        drive(1, 32'h10, 3'b010, 32'h11111111, 4'b1111);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rr_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rr_rdata", rdata, 32'h0);
        check("rr_misaligned", 32'(misaligned), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rr_req_ready", 32'(req_ready), 32'h1);
        drive(0, 32'h10, 3'b010, 32'h0, 4'b0000);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rr_store_dropped", rdata, 32'hDEADBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
